// File: rtl/bip_pkg.sv
// Shared definitions for the BIP processor: opcode map, accumulator-path
// select encodings and the control strobe bundle.
package bip_pkg;

  localparam int OPCODE_LENGTH_DEFAULT = 5;

  localparam int unsigned OP_HLT  = 0;
  localparam int unsigned OP_STO  = 1;
  localparam int unsigned OP_LD   = 2;
  localparam int unsigned OP_LDI  = 3;
  localparam int unsigned OP_ADD  = 4;
  localparam int unsigned OP_ADDI = 5;
  localparam int unsigned OP_SUB  = 6;
  localparam int unsigned OP_SUBI = 7;

  localparam logic SEL_A_OPERAND = 1'b0;
  localparam logic SEL_A_ALU     = 1'b1;
  localparam logic SEL_B_RAM     = 1'b0;
  localparam logic SEL_B_IMM     = 1'b1;

  typedef struct packed {
    logic wr_pc;
    logic wr_acc;
    logic sel_a;
    logic sel_b;
    logic wr_ram;
    logic rd_ram;
  } ctrl_t;

endpackage

// File: rtl/instruction_decoder.sv
// BIP control decoder: combinational opcode decode feeding one output
// register stage, so strobes appear one cycle after the opcode is sampled.
module instruction_decoder
  import bip_pkg::*;
#(
  parameter int OPCODE_LENGTH = OPCODE_LENGTH_DEFAULT
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [OPCODE_LENGTH-1:0] i_opcode,
  output logic                     o_wrPC,
  output logic                     o_wrACC,
  output logic                     o_selA,
  output logic                     o_selB,
  output logic [OPCODE_LENGTH-1:0] o_opcode,
  output logic                     o_wrRAM,
  output logic                     o_rdRAM
);

  ctrl_t                     ctrl_d;
  ctrl_t                     ctrl_q;
  logic [OPCODE_LENGTH-1:0]  opcode_q;

  // Undefined opcodes fall through to the default: PC advances, nothing written.
  always_comb begin
    ctrl_d       = '0;
    ctrl_d.wr_pc = 1'b1;
    case (i_opcode)
      OPCODE_LENGTH'(OP_HLT): ctrl_d.wr_pc = 1'b0;
      OPCODE_LENGTH'(OP_STO): ctrl_d.wr_ram = 1'b1;
      OPCODE_LENGTH'(OP_LD): begin
        ctrl_d.wr_acc = 1'b1;
        ctrl_d.sel_a  = SEL_A_OPERAND;
        ctrl_d.sel_b  = SEL_B_RAM;
        ctrl_d.rd_ram = 1'b1;
      end
      OPCODE_LENGTH'(OP_LDI): begin
        ctrl_d.wr_acc = 1'b1;
        ctrl_d.sel_a  = SEL_A_OPERAND;
        ctrl_d.sel_b  = SEL_B_IMM;
      end
      OPCODE_LENGTH'(OP_ADD),
      OPCODE_LENGTH'(OP_SUB): begin
        ctrl_d.wr_acc = 1'b1;
        ctrl_d.sel_a  = SEL_A_ALU;
        ctrl_d.sel_b  = SEL_B_RAM;
        ctrl_d.rd_ram = 1'b1;
      end
      OPCODE_LENGTH'(OP_ADDI),
      OPCODE_LENGTH'(OP_SUBI): begin
        ctrl_d.wr_acc = 1'b1;
        ctrl_d.sel_a  = SEL_A_ALU;
        ctrl_d.sel_b  = SEL_B_IMM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      ctrl_q   <= '0;
      opcode_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      opcode_q <= i_opcode;
    end
  end

  assign o_wrPC   = ctrl_q.wr_pc;
  assign o_wrACC  = ctrl_q.wr_acc;
  assign o_selA   = ctrl_q.sel_a;
  assign o_selB   = ctrl_q.sel_b;
  assign o_wrRAM  = ctrl_q.wr_ram;
  assign o_rdRAM  = ctrl_q.rd_ram;
  assign o_opcode = opcode_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: reset, opcode sweep, strobes,
// undefined opcodes, HLT hold and asynchronous mid-stream reset.
module tb_instruction_decoder;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [4:0] i_opcode;
  logic       o_wrPC, o_wrACC, o_selA, o_selB, o_wrRAM, o_rdRAM;
  logic [4:0] o_opcode;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_decoder #(.OPCODE_LENGTH(5)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_opcode (i_opcode),
    .o_wrPC   (o_wrPC),
    .o_wrACC  (o_wrACC),
    .o_selA   (o_selA),
    .o_selB   (o_selB),
    .o_opcode (o_opcode),
    .o_wrRAM  (o_wrRAM),
    .o_rdRAM  (o_rdRAM)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ctrl_vec();
    return {o_wrPC, o_wrACC, o_selA, o_selB, o_wrRAM, o_rdRAM};
  endfunction

  // Hand-written decode table: wrPC/wrACC/selA/selB/wrRAM/rdRAM.
  function automatic logic [5:0] exp_ctrl(input int op);
    case (op)
      0:       return 6'b000000;
      1:       return 6'b100010;
      2:       return 6'b110001;
      3:       return 6'b110100;
      4:       return 6'b111001;
      5:       return 6'b111100;
      6:       return 6'b111001;
      7:       return 6'b111100;
      default: return 6'b100000;
    endcase
  endfunction

  // Drive at the falling edge, check at the next falling edge; also confirm
  // the output has not moved before the intervening rising edge.
  task automatic apply_and_check(input string tag, input int op);
    logic [4:0] prev_op;
    prev_op  = o_opcode;
    i_opcode = 5'(op);
    #1;
    check({tag, "_hold"}, 32'(o_opcode), 32'(prev_op));
    @(negedge i_clock);
    check({tag, "_ctrl"}, 32'(ctrl_vec()), 32'(exp_ctrl(op)));
    check({tag, "_op"}, 32'(o_opcode), 32'(op));
    $display("[TB] %s op=%05b ctrl=%06b o_opcode=%05b", tag, 5'(op), ctrl_vec(), o_opcode);
  endtask

  initial begin
    i_reset  = 1'b0;
    i_opcode = 5'b00011;
    #1;
    check("reset_ctrl", 32'(ctrl_vec()), 32'h0);
    check("reset_op", 32'(o_opcode), 32'h0);

    @(negedge i_clock);
    check("reset_held_ctrl", 32'(ctrl_vec()), 32'h0);
    i_reset = 1'b1;
    @(negedge i_clock);
    check("release_ctrl", 32'(ctrl_vec()), 32'(6'b110100));
    check("release_op", 32'(o_opcode), 32'd3);

    for (int i = 0; i < 8; i++) apply_and_check("sweep", i);

    for (int i = 0; i < 32; i++) begin
      apply_and_check("all32", i);
      check("all32_excl", 32'(o_wrRAM & o_rdRAM), 32'h0);
    end

    apply_and_check("undef08", 8);
    apply_and_check("undef21", 21);
    apply_and_check("undef31", 31);

    for (int i = 0; i < 3; i++) begin
      apply_and_check("hlt", 0);
      check("hlt_wrpc", 32'(o_wrPC), 32'h0);
    end
    apply_and_check("hlt_exit", 4);
    check("hlt_exit_ctrl", 32'(ctrl_vec()), 32'(6'b111001));

    apply_and_check("sto", 1);
    check("sto_wrram", 32'(o_wrRAM), 32'h1);
    #2;
    i_reset = 1'b0;
    #1;
    check("midrst_wrram", 32'(o_wrRAM), 32'h0);
    check("midrst_ctrl", 32'(ctrl_vec()), 32'h0);
    check("midrst_op", 32'(o_opcode), 32'h0);
    $display("[TB] midrst ctrl=%06b o_opcode=%05b", ctrl_vec(), o_opcode);
    @(negedge i_clock);
    i_reset = 1'b1;
    apply_and_check("post_rst", 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
